ingress_frame_writer: RTL and testbench
=======================================

# ingress_frame_writer

Switch-clock-domain ingress block that is the write-side counterpart of the egress read path. It takes the received byte stream (already in `switch_clk`) and packs it into `BLOCK_BYTES`-wide blocks. It writes those blocks into frame memory at an allocated start address, and on a clean frame end issues a VOQ write request carrying the start pointer and a flood flag. Errored frames are aborted: memory is told to free the chain and nothing reaches the VOQ.

## Interface
- `ADDR_W`, default `mem_pkg::ADDR_W`: frame-memory block address width.
- `DATA_WIDTH`, default `rx_tx_pkg::DATA_WIDTH` (8): stream beat width.
- `BLOCK_BYTES`, default `mem_pkg::BLOCK_BYTES`: beats per memory block; power of two, ≥2.
- `switch_clk`  in  1  switch clock; the only clock.
- `switch_rst_n`  in  1  asynchronous, active-low reset.
- `rx_data_i`  in  DATA_WIDTH  stream byte.
- `rx_valid_i`  in  1  beat valid.
- `rx_sof_i`  in  1  first byte of frame.
- `rx_eof_i`  in  1  last byte of frame.
- `rx_err_i`  in  1  frame error flagged on this beat.
- `rx_ready_o`  out  1  beat accepted when `rx_valid_i & rx_ready_o`.
- `mem_alloc_req_o`  out  1  request a start block address.
- `mem_alloc_valid_i`  in  1  start address valid; completes the allocation.
- `mem_alloc_addr_i`  in  ADDR_W  allocated start address.
- `mem_we_o`  out  1  block write request; held until `mem_ready_i`.
- `mem_ready_i`  in  1  memory accepts the block this cycle.
- `mem_start_o`  out  1  the current block is the first block of its frame.
- `mem_last_o`  out  1  the current block is the last block of its frame.
- `mem_last_bytes_o`  out  $clog2(BLOCK_BYTES)+1  valid bytes in the current block, 1..BLOCK_BYTES.
- `mem_block_o`  out  [BLOCK_BYTES-1:0][DATA_WIDTH-1:0]  block data; byte 0 is the earliest beat.
- `mem_abort_o`  out  1  one-cycle pulse: free the chain at `mem_start_addr_o`.
- `mem_start_addr_o`  out  ADDR_W  latched start address of the current frame.
- `voq_write_req_o`  out  1  one-cycle enqueue pulse.
- `voq_ptr_o`  out  ADDR_W  frame start pointer; valid with `voq_write_req_o`.
- `flood_o`  out  1  flood flag; valid with `voq_write_req_o`.

## Operation
- **IDLE**
  - `rx_ready_o`=0.
  - `rx_valid_i & rx_sof_i` → ALLOC.
  - Valid beats without SOF are consumed and discarded: ready=1 for non-SOF beats only.
- **ALLOC**
  - `mem_alloc_req_o`=1 until `mem_alloc_valid_i`.
  - On `mem_alloc_valid_i`, latch `mem_alloc_addr_i` → FILL.
- **FILL**
  - `rx_ready_o`=1; each accepted beat is stored at index `fill_cnt`.
  - Byte 0 of the frame: `flood` latches `rx_data_i[0]` (group bit; broadcast and multicast flood).
  - Any accepted beat with `rx_err_i` sets `err`.
  - If `err` is set and a beat is not EOF, stay in FILL and write nothing further (discard mode).
  - Beat that fills the block, or EOF beat → FLUSH, unless `err` is set.
  - EOF with `err` set → ABORT.
- **FLUSH**
  - `rx_ready_o`=0, `mem_we_o`=1.
  - `mem_start_o`=1 for the first block of the frame.
  - `mem_last_o`=1 if the block holds the EOF beat.
  - On `mem_ready_i`: last block → COMMIT; otherwise clear `fill_cnt` → FILL.
- **COMMIT**: `voq_write_req_o`=1 for one cycle with `voq_ptr_o`=start address and `flood_o`=`flood` → IDLE.
- **ABORT**: `mem_abort_o`=1 for one cycle → IDLE. Abort is issued even when zero blocks were written, because the start block is already allocated.
- An SOF arriving while FILL is in progress (missing EOF) is treated as an error; the current frame goes to ABORT after that beat.
- `fill_cnt` is $clog2(BLOCK_BYTES)+1 bits.
- Frame byte counter is 16 bits and saturates at 0xFFFF.

## Timing
- Reset: all outputs 0, state IDLE, counters and flags cleared.
  - Reset is asynchronous at any point.
  - A partially written chain is not aborted; memory reset covers it.
- SOF seen in IDLE → `mem_alloc_req_o` the next cycle.
- Alloc grant → `rx_ready_o`=1 the next cycle.
- Block complete → `mem_we_o` the next cycle.
- `mem_block_o`, `mem_start_o`, `mem_last_o` and `mem_last_bytes_o` are stable while `mem_we_o` is held.
- Last-block `mem_ready_i` → `voq_write_req_o` the next cycle.
- Minimum gap: one idle cycle between COMMIT/ABORT and the next ALLOC.
- `mem_ready_i` asserted outside FLUSH is ignored.
- `mem_alloc_valid_i` asserted outside ALLOC is ignored.
- EOF on the first beat is a 1-byte frame: `mem_last_bytes_o`=1, `mem_start_o`=`mem_last_o`=1.

## Configuration
- `INGRESS_RUNT_DROP_EN` defined: an EOF with frame byte count < 64 is treated as an error → ABORT, no VOQ write.
- Undefined: any frame of length ≥1 without `rx_err_i` is committed.

## Test plan
- Frame from 02:… of 20 bytes, BLOCK_BYTES=8, macro undefined, `mem_ready_i` always 1, alloc addr 0x15:
  - three blocks written; `mem_last_bytes_o`=4 on the last;
  - `voq_write_req_o` pulses with `voq_ptr_o`=0x15, `flood_o`=0.
- Broadcast frame FF:FF:… of 64 bytes → `flood_o`=1, eight writes, `mem_start_o` only on the first write.
- `mem_ready_i` held low 5 cycles during the second block → `rx_ready_o`=0 and data stable throughout; no beat lost; byte order verified.
- `rx_err_i` on byte 10 of a 30-byte frame:
  - one block written, then discard mode;
  - `mem_abort_o` pulses at EOF with addr 0x15;
  - `voq_write_req_o` never pulses.
- `INGRESS_RUNT_DROP_EN` defined:
  - 40-byte frame → ABORT;
  - 64-byte frame → COMMIT.
- Reset asserted mid-FLUSH:
  - all outputs 0 immediately;
  - next SOF proceeds normally from ALLOC.

Source files
------------

// File: rtl/ingress_frame_writer.sv
// Packs the received switch_clk byte stream into BLOCK_BYTES-wide frame-memory blocks.
// Committed frames are enqueued to the VOQ and errored frames are aborted. Optional: INGRESS_RUNT_DROP_EN.
module ingress_frame_writer #(
  parameter int ADDR_W      = 10,  // mem_pkg::ADDR_W
  parameter int DATA_WIDTH  = 8,   // rx_tx_pkg::DATA_WIDTH
  parameter int BLOCK_BYTES = 8    // mem_pkg::BLOCK_BYTES
) (
  input  logic                                   switch_clk,
  input  logic                                   switch_rst_n,
  input  logic [DATA_WIDTH-1:0]                  rx_data_i,
  input  logic                                   rx_valid_i,
  input  logic                                   rx_sof_i,
  input  logic                                   rx_eof_i,
  input  logic                                   rx_err_i,
  output logic                                   rx_ready_o,
  output logic                                   mem_alloc_req_o,
  input  logic                                   mem_alloc_valid_i,
  input  logic [ADDR_W-1:0]                      mem_alloc_addr_i,
  output logic                                   mem_we_o,
  input  logic                                   mem_ready_i,
  output logic                                   mem_start_o,
  output logic                                   mem_last_o,
  output logic [$clog2(BLOCK_BYTES):0]           mem_last_bytes_o,
  output logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] mem_block_o,
  output logic                                   mem_abort_o,
  output logic [ADDR_W-1:0]                      mem_start_addr_o,
  output logic                                   voq_write_req_o,
  output logic [ADDR_W-1:0]                      voq_ptr_o,
  output logic                                   flood_o
);

  localparam int IDX_W = $clog2(BLOCK_BYTES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALLOC  = 3'd1,
    FILL   = 3'd2,
    FLUSH  = 3'd3,
    COMMIT = 3'd4,
    ABORT  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                      fill_cnt;
  logic [15:0]                           byte_cnt;
  logic [BLOCK_BYTES-1:0][DATA_WIDTH-1:0] blk;
  logic [ADDR_W-1:0]                     start_addr;
  logic                                  flood;
  logic                                  err;
  logic                                  first_blk;
  logic                                  last_blk;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        beat;
  logic        sof_mid;
  logic        err_nxt;
  logic        runt;
  logic        store;
  logic [15:0] byte_cnt_nxt;

  // An SOF after byte 0 means the previous frame lost its EOF.
  assign beat         = rx_valid_i & (state == FILL);
  assign byte_cnt_nxt = sat_inc16(byte_cnt);
  assign sof_mid      = rx_sof_i & (byte_cnt != 16'd0);
  assign err_nxt      = err | rx_err_i | sof_mid;
  assign store        = beat & ~err_nxt;

`ifdef INGRESS_RUNT_DROP_EN
  assign runt = rx_eof_i & (byte_cnt_nxt < 16'd64);
`else
  assign runt = 1'b0;
`endif

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    rx_ready_o      = 1'b0;
    mem_alloc_req_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_abort_o     = 1'b0;
    voq_write_req_o = 1'b0;
    case (state)
      IDLE: begin
        // The SOF beat is left on the bus so FILL can take it as byte 0.
        rx_ready_o = rx_valid_i & ~rx_sof_i;
        if (rx_valid_i & rx_sof_i) state_nxt = ALLOC;
      end
      ALLOC: begin
        mem_alloc_req_o = 1'b1;
        if (mem_alloc_valid_i) state_nxt = FILL;
      end
      FILL: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (sof_mid)                                state_nxt = ABORT;
          else if (rx_eof_i)                          state_nxt = (err_nxt | runt) ? ABORT : FLUSH;
          else if (!err_nxt && fill_cnt == LAST_IDX)  state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        mem_we_o = 1'b1;
        if (mem_ready_i) state_nxt = last_blk ? COMMIT : FILL;
      end
      COMMIT: begin
        voq_write_req_o = 1'b1;
        state_nxt       = IDLE;
      end
      ABORT: begin
        mem_abort_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      fill_cnt   <= '0;
      byte_cnt   <= '0;
      blk        <= '0;
      start_addr <= '0;
      flood      <= 1'b0;
      err        <= 1'b0;
      first_blk  <= 1'b0;
      last_blk   <= 1'b0;
    end else begin
      case (state)
        ALLOC: begin
          if (mem_alloc_valid_i) begin
            start_addr <= mem_alloc_addr_i;
            fill_cnt   <= '0;
            byte_cnt   <= '0;
            flood      <= 1'b0;
            err        <= 1'b0;
            first_blk  <= 1'b1;
            last_blk   <= 1'b0;
          end
        end
        FILL: begin
          if (beat) begin
            byte_cnt <= byte_cnt_nxt;
            err      <= err_nxt;
            // Group bit of the destination MAC selects flooding.
            if (byte_cnt == 16'd0) flood <= rx_data_i[0];
            if (store) begin
              blk[fill_cnt[IDX_W-1:0]] <= rx_data_i;
              fill_cnt                 <= fill_cnt + CNT_W'(1);
              if (rx_eof_i) last_blk <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (mem_ready_i && !last_blk) begin
            fill_cnt  <= '0;
            first_blk <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_start_o      = (state == FLUSH) & first_blk;
  assign mem_last_o       = (state == FLUSH) & last_blk;
  assign mem_last_bytes_o = (state == FLUSH) ? fill_cnt : '0;
  assign mem_block_o      = blk;
  assign mem_start_addr_o = start_addr;
  assign voq_ptr_o        = start_addr;
  assign flood_o          = flood;

endmodule

// File: tb/tb_ingress_frame_writer.sv
// Randomized self-checking bench for ingress_frame_writer against a frame-level reference model.
module tb_ingress_frame_writer;

  localparam int ADDR_W = 10;
  localparam int DW     = 8;
  localparam int BB     = 8;
`ifdef INGRESS_RUNT_DROP_EN
  localparam bit RUNT_DROP = 1'b1;
`else
  localparam bit RUNT_DROP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [DW-1:0]           rx_data_i = '0;
  logic                    rx_valid_i = 1'b0;
  logic                    rx_sof_i = 1'b0;
  logic                    rx_eof_i = 1'b0;
  logic                    rx_err_i = 1'b0;
  logic                    rx_ready_o;
  logic                    mem_alloc_req_o;
  logic                    mem_alloc_valid_i = 1'b0;
  logic [ADDR_W-1:0]       mem_alloc_addr_i = '0;
  logic                    mem_we_o;
  logic                    mem_ready_i = 1'b1;
  logic                    mem_start_o;
  logic                    mem_last_o;
  logic [$clog2(BB):0]     mem_last_bytes_o;
  logic [BB-1:0][DW-1:0]   mem_block_o;
  logic                    mem_abort_o;
  logic [ADDR_W-1:0]       mem_start_addr_o;
  logic                    voq_write_req_o;
  logic [ADDR_W-1:0]       voq_ptr_o;
  logic                    flood_o;

  always #5 clk = ~clk;

  ingress_frame_writer #(.ADDR_W(ADDR_W), .DATA_WIDTH(DW), .BLOCK_BYTES(BB)) dut (
    .switch_clk(clk), .switch_rst_n(rst_n),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_sof_i(rx_sof_i),
    .rx_eof_i(rx_eof_i), .rx_err_i(rx_err_i), .rx_ready_o(rx_ready_o),
    .mem_alloc_req_o(mem_alloc_req_o), .mem_alloc_valid_i(mem_alloc_valid_i),
    .mem_alloc_addr_i(mem_alloc_addr_i), .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i),
    .mem_start_o(mem_start_o), .mem_last_o(mem_last_o), .mem_last_bytes_o(mem_last_bytes_o),
    .mem_block_o(mem_block_o), .mem_abort_o(mem_abort_o), .mem_start_addr_o(mem_start_addr_o),
    .voq_write_req_o(voq_write_req_o), .voq_ptr_o(voq_ptr_o), .flood_o(flood_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        start;
    logic        last;
    int          lb;
  } wr_t;

  wr_t               wr_q[$];
  int                voq_cnt = 0;
  int                abort_cnt = 0;
  logic [ADDR_W-1:0] voq_ptr_seen = '0;
  logic [ADDR_W-1:0] abort_addr_seen = '0;
  logic              flood_seen = 1'b0;
  logic [ADDR_W-1:0] alloc_addr = 10'h015;
  int                ready_mode = 0;
  int                stall_cnt = 0;

  // Monitor: sampled on the falling edge, handshakes complete on the next rising edge.
  initial begin
    logic        prev_stall;
    logic [63:0] prev_blk;
    logic [5:0]  prev_ctl;
    wr_t         w;
    prev_stall = 1'b0;
    prev_blk   = '0;
    prev_ctl   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_val("we_held", mem_we_o, 1);
          check_val("blk_stable", mem_block_o, prev_blk);
          check_val("ctl_stable", {mem_start_o, mem_last_o, mem_last_bytes_o}, prev_ctl);
        end
        if (mem_we_o) check_val("rdy_in_flush", rx_ready_o, 0);
        if (mem_we_o && mem_ready_i) begin
          w.data  = mem_block_o;
          w.start = mem_start_o;
          w.last  = mem_last_o;
          w.lb    = int'(mem_last_bytes_o);
          wr_q.push_back(w);
        end
        if (voq_write_req_o) begin
          voq_cnt++;
          voq_ptr_seen = voq_ptr_o;
          flood_seen   = flood_o;
        end
        if (mem_abort_o) begin
          abort_cnt++;
          abort_addr_seen = mem_start_addr_o;
        end
        prev_stall = mem_we_o && !mem_ready_i;
        prev_blk   = mem_block_o;
        prev_ctl   = {mem_start_o, mem_last_o, mem_last_bytes_o};
      end
    end
  end

  // Memory ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: mem_ready_i = 1'b1;
      1: mem_ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (mem_we_o && wr_q.size() == 1 && stall_cnt < 5) begin
          mem_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          mem_ready_i = 1'b1;
        end
      end
      default: mem_ready_i = 1'b0;
    endcase
  end

  // Allocator: random grant latency, stray valids with junk addresses outside ALLOC.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      mem_alloc_valid_i = 1'b0;
    end else if (mem_alloc_req_o && $urandom_range(0, 2) == 0) begin
      mem_alloc_valid_i = 1'b1;
      mem_alloc_addr_i  = alloc_addr;
      @(negedge clk);
      @(posedge clk); #1;
      mem_alloc_valid_i = 1'b0;
      @(negedge clk);
      check_val("grant_to_ready", rx_ready_o, 1);
    end else if (mem_alloc_req_o) begin
      mem_alloc_valid_i = 1'b0;
    end else begin
      mem_alloc_valid_i = ($urandom_range(0, 7) == 0);
      mem_alloc_addr_i  = ADDR_W'($urandom);
    end
  end

  task automatic drive_beat(input logic [7:0] d, input bit sof, input bit eof, input bit er,
                            input bit lat_chk);
    int t;
    @(posedge clk); #1;
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    rx_sof_i   = sof;
    rx_eof_i   = eof;
    rx_err_i   = er;
    if (lat_chk) begin
      @(negedge clk);
      check_val("idle_sof_not_taken", rx_ready_o, 0);
      @(negedge clk);
      check_val("alloc_req_latency", mem_alloc_req_o, 1);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ready_o && t < 400);
    if (!rx_ready_o) check_val("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    rx_sof_i   = 1'b0;
    rx_eof_i   = 1'b0;
    rx_err_i   = 1'b0;
  endtask

  // Reference model: outcome of a frame from its length, error position and truncation.
  task automatic check_outcome(input logic [7:0] fb[$], input int len, input int err_idx,
                               input bit trunc);
    bit commit;
    int nblk;
    commit = 1'b0;
    if (trunc)                           nblk = len / BB;
    else if (err_idx >= 0)               nblk = err_idx / BB;
    else if (RUNT_DROP && len < 64)      nblk = (len - 1) / BB;
    else begin
      commit = 1'b1;
      nblk   = (len + BB - 1) / BB;
    end
    check_val("blk_count", wr_q.size(), nblk);
    for (int i = 0; i < wr_q.size() && i < nblk; i++) begin
      int          nb;
      logic [63:0] e;
      logic [63:0] m;
      nb = (commit && i == nblk - 1) ? len - BB * i : BB;
      e  = '0;
      m  = '0;
      for (int b = 0; b < nb; b++) begin
        e[b*8 +: 8] = fb[i*BB + b];
        m[b*8 +: 8] = 8'hFF;
      end
      check_val("blk_data", wr_q[i].data & m, e);
      check_val("blk_start", wr_q[i].start, (i == 0));
      check_val("blk_last", wr_q[i].last, (commit && i == nblk - 1));
      check_val("blk_bytes", wr_q[i].lb, nb);
    end
    check_val("voq_pulses", voq_cnt, commit);
    check_val("abort_pulses", abort_cnt, !commit);
    if (commit) begin
      check_val("voq_ptr", voq_ptr_seen, alloc_addr);
      check_val("flood", flood_seen, fb[0][0]);
    end else begin
      check_val("abort_addr", abort_addr_seen, alloc_addr);
    end
  endtask

  task automatic run_frame(input int len, input logic [7:0] b0, input int err_idx,
                           input int trunc_b, input bit gaps);
    logic [7:0] fb[$];
    int t;
    fb.delete();
    fb.push_back(b0);
    for (int i = 1; i < len; i++) fb.push_back(8'($urandom));
    wr_q.delete();
    voq_cnt   = 0;
    abort_cnt = 0;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle_bus();
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      drive_beat(fb[i], (i == 0), (i == len - 1) && (trunc_b == 0), (i == err_idx), (i == 0));
    end
    for (int j = 0; j < trunc_b; j++)
      drive_beat(8'($urandom), (j == 0), (j == trunc_b - 1), 1'b0, 1'b0);
    idle_bus();
    t = 0;
    while (voq_cnt + abort_cnt == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check_outcome(fb, len, err_idx, (trunc_b > 0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ctl"}, {rx_ready_o, mem_alloc_req_o, mem_we_o, mem_start_o, mem_last_o,
                              mem_abort_o, voq_write_req_o, flood_o}, 0);
    check_val({tag, "_last_bytes"}, mem_last_bytes_o, 0);
    check_val({tag, "_block"}, mem_block_o, 0);
    check_val({tag, "_addr"}, {mem_start_addr_o, voq_ptr_o}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, eidx, tb_len, t;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Non-SOF beats in IDLE are swallowed without starting a frame.
    for (int i = 0; i < 3; i++) drive_beat(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bus();
    @(negedge clk);
    check_val("no_alloc_on_garbage", mem_alloc_req_o, 0);

    alloc_addr = 10'h015;
    ready_mode = 0;
    run_frame(20, 8'h02, -1, 0, 1'b0);
    run_frame(64, 8'hFF, -1, 0, 1'b0);

    ready_mode = 2;
    stall_cnt  = 0;
    run_frame(24, 8'h10, -1, 0, 1'b0);
    ready_mode = 0;

    run_frame(30, 8'h03, 10, 0, 1'b0);
    run_frame(40, 8'h00, -1, 0, 1'b0);
    run_frame(64, 8'h00, -1, 0, 1'b0);
    run_frame(1, 8'h01, -1, 0, 1'b0);
    run_frame(13, 8'h05, -1, 5, 1'b0);
    run_frame(16, 8'h00, -1, 3, 1'b0);
    run_frame(17, 8'h01, 7, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      alloc_addr = ADDR_W'($urandom);
      ready_mode = $urandom_range(0, 1);
      len        = $urandom_range(1, 90);
      eidx       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      tb_len     = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 0;
      if (tb_len > 0) eidx = -1;
      run_frame(len, 8'($urandom), eidx, tb_len, 1'b1);
    end

    // Reset while a block is stuck in FLUSH.
    ready_mode = 3;
    alloc_addr = 10'h02A;
    wr_q.delete();
    for (int i = 0; i < 8; i++)
      drive_beat(8'($urandom), (i == 0), (i == 7), 1'b0, 1'b0);
    idle_bus();
    t = 0;
    while (!mem_we_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("flush_reached", mem_we_o, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    ready_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    alloc_addr = 10'h015;
    run_frame(20, 8'h02, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
